// File: rtl/seven_segment_mux_if.sv
// Display-side bundle: four BCD digits, dp/blank masks in; scanned anode/segment/dp_n out.
// No latency of its own; no backpressure, the display scan free-runs.
// Leading-zero blanking (SSD_LEADING_ZERO_BLANK_EN) lives in the driver, not here.
interface seven_segment_mux_if;
    logic [3:0] digit0;
    logic [3:0] digit1;
    logic [3:0] digit2;
    logic [3:0] digit3;
    logic [3:0] dp;
    logic [3:0] blank;
    logic [6:0] segment;
    logic       dp_n;
    logic [3:0] anode;

    modport master (
        output digit0, digit1, digit2, digit3, dp, blank,
        input  segment, dp_n, anode
    );

    modport slave (
        input  digit0, digit1, digit2, digit3, dp, blank,
        output segment, dp_n, anode
    );
endinterface

// File: rtl/seven_segment_mux.sv
// 4-digit common-anode scanner: BCD/hex decode, dp and blank mask; optional SSD_LEADING_ZERO_BLANK_EN.
// Latency: 1 cycle from any input to the registered anode/segment/dp_n.
// Backpressure: none; each slot holds for REFRESH_COUNT cycles regardless of inputs.
module seven_segment_mux #(
    parameter int REFRESH_COUNT = 100000
) (
    input  logic                i_clk,
    input  logic                i_reset,
    seven_segment_mux_if.slave  bus
);

    localparam int CNT_W = (REFRESH_COUNT > 1) ? $clog2(REFRESH_COUNT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_COUNT - 1);

    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_sel;
    logic [3:0]       r_anode;
    logic [6:0]       r_segment;
    logic             r_dp_n;

    logic [3:0]       w_digit;
    logic [3:0]       w_lz;
    logic             w_dark;
    logic [3:0]       w_anode;
    logic [6:0]       w_segment;
    logic             w_dp_n;

    function automatic logic [6:0] f_decode(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

`ifdef SSD_LEADING_ZERO_BLANK_EN
    // Slot 0 always shows, so a zero reading is never fully dark.
    assign w_lz = {
        (bus.digit3 == 4'h0),
        (bus.digit3 == 4'h0) && (bus.digit2 == 4'h0),
        (bus.digit3 == 4'h0) && (bus.digit2 == 4'h0) && (bus.digit1 == 4'h0),
        1'b0
    };
`else
    assign w_lz = 4'b0000;
`endif

    always_comb begin
        w_digit = bus.digit0;
        case (r_sel)
            2'd1:    w_digit = bus.digit1;
            2'd2:    w_digit = bus.digit2;
            2'd3:    w_digit = bus.digit3;
            default: w_digit = bus.digit0;
        endcase

        w_dark    = bus.blank[r_sel] | w_lz[r_sel];
        w_anode   = 4'b1111;
        w_segment = 7'b1111111;
        w_dp_n    = 1'b1;
        if (!w_dark) begin
            w_anode   = ~(4'b0001 << r_sel);
            w_segment = f_decode(w_digit);
            w_dp_n    = ~bus.dp[r_sel];
        end
    end

    // All three outputs load from r_sel on the same edge, so a pattern can never
    // land on a neighbouring anode; r_sel advances only after its slot's last load.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cnt     <= '0;
            r_sel     <= 2'd0;
            r_anode   <= 4'b1111;
            r_segment <= 7'b1111111;
            r_dp_n    <= 1'b1;
        end else begin
            if (r_cnt == CNT_MAX) begin
                r_cnt <= '0;
                r_sel <= r_sel + 2'd1;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            r_anode   <= w_anode;
            r_segment <= w_segment;
            r_dp_n    <= w_dp_n;
        end
    end

    assign bus.anode   = r_anode;
    assign bus.segment = r_segment;
    assign bus.dp_n    = r_dp_n;

endmodule

// File: doc/seven_segment_mux.md
# seven_segment_mux

Time-multiplexed driver for a 4-digit common-anode seven-segment display. It sits directly downstream of the stopwatch counter chain and consumes its four BCD digit outputs, digit0 (least significant) through digit3. Each cycle it scans one digit and drives that digit's active-low anode together with its decoded active-low segment pattern. A per-digit decimal-point request and a per-digit blank mask are also supported.

## Interface
- REFRESH_COUNT, default 100000: clock cycles each digit slot is held (1 ms at 100 MHz). Legal range is ≥1.
- CNT_W, default $clog2(REFRESH_COUNT): refresh counter width. Derived; never overridden.
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- digit0  in  4  value shown in slot 0 (rightmost digit).
- digit1  in  4  value shown in slot 1.
- digit2  in  4  value shown in slot 2.
- digit3  in  4  value shown in slot 3 (leftmost digit).
- dp  in  4  decimal-point request, active-high, bit i maps to slot i.
- blank  in  4  forces slot i dark, active-high.
- segment  out  7  active-low segments, bit 0 = a through bit 6 = g.
- dp_n  out  1  active-low decimal point.
- anode  out  4  active-low digit enables, at most one bit low at a time.

## Operation
- **Refresh counter** counts 0..REFRESH_COUNT-1 and wraps to 0. At the wrap, the 2-bit slot select advances 0→1→2→3→0.
- **Decode** (segment[6:0] = gfedcba, active-low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- **Active slot i, not dark:**
  - anode = all ones except bit i = 0.
  - segment = decode(digit_i).
  - dp_n = ~dp[i].
- **Dark slot** (blank[i]=1, or leading-zero blanked per Configuration):
  - anode = 4'b1111, segment = 7'b1111111, dp_n = 1.
  - The slot still consumes its full REFRESH_COUNT cycles, so display duty cycle is unchanged.
- **Output registers:** anode, segment and dp_n are all registered and loaded from the same select value. A segment pattern never appears on the wrong anode, even for one cycle.
- **Input sampling:** digit, dp and blank inputs are sampled every cycle with no hold requirement. A change mid-slot is visible on the outputs one cycle later.

## Timing
- **Reset values:** counter=0, select=0, anode=4'b1111, segment=7'b1111111, dp_n=1.
- **Reset precedence:** reset asserted in any cycle overrides everything. Outputs take their reset values at that edge.
- **After reset release:** the first edge with reset low loads slot 0 onto the outputs. Every slot, including the first, is then held for exactly REFRESH_COUNT cycles.
- **Latency:** 1 cycle from an input change to the output change.
- **REFRESH_COUNT=1:** select advances every cycle; the anode rotates 1110→1101→1011→0111 on consecutive cycles.
- **Reset mid-slot:** the scan restarts at slot 0 with a full-length slot. No partial slot is produced.
- **Simultaneous events:** a counter wrap on the same edge as an input change shows the new slot with the new input values.

## Configuration
- **SSD_LEADING_ZERO_BLANK_EN defined:**
  - Slot 3 is dark when digit3==0.
  - Slot 2 is dark when digit3==0 and digit2==0.
  - Slot 1 is dark when digit3, digit2 and digit1 are all 0.
  - Slot 0 is never leading-zero blanked.
  - The leading-zero rule ORs with blank[i].
  - A leading-zero-dark slot suppresses dp_n for that slot.
- **Not defined:** only blank[i] darkens a slot; zeros display normally.

## Test plan
- **Reset hold:** reset=1 for 10 cycles with arbitrary inputs → anode=1111, segment=1111111 and dp_n=1 on every cycle.
- **Scan order:** REFRESH_COUNT=4, digit3..0=4,3,2,1, dp=0 → after release, anode=1110/segment=1111001 for 4 cycles, then 1101/0100100, then 1011/0110000, then 0111/0011001, then back to 1110.
- **Hex decode and decimal point:** REFRESH_COUNT=1, dp=4'b0100, digit inputs stepped through A..F → segment matches the decode list each slot, and dp_n=0 only while anode=1011.
- **Blank mask:** blank=4'b0100 → during slot 2, anode=1111 and segment=1111111 for 4 cycles. The other slots are unaffected and the total period stays 16 cycles.
- **Leading-zero blanking (macro on):**
  - digit3..0=0,0,5,7 → slots 3 and 2 dark, 5 and 7 shown.
  - 0,1,0,0 → only slot 3 dark.
  - 0,0,0,0 → only slot 0 lit, showing 1000000.
- **Reset mid-scan:** assert reset for 1 cycle in the middle of slot 2 → outputs take reset values at that edge. The next edge shows slot 0, held for the full 4 cycles.
